// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: ALU opcodes and the FSM
// state encoding the hazard unit decodes.
package alu_mul_seq_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;

    // Two-bit encoding is fixed so external decoders can match on it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_alu_src_mux.sv
// ALU input selector: pipeline controls pass through unless the multiply
// sequencer owns the ALU.
module alu_src_mux #(
    parameter int unsigned XLEN = 32
) (
    input  logic            seq_sel,
    input  logic [3:0]      pipe_alu_ctrl,
    input  logic [XLEN-1:0] pipe_op_a,
    input  logic [XLEN-1:0] pipe_op_b,
    input  logic [3:0]      seq_alu_ctrl,
    input  logic [XLEN-1:0] seq_op_a,
    input  logic [XLEN-1:0] seq_op_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_op_a,
    output logic [XLEN-1:0] alu_op_b
);

    always_comb begin
        if (seq_sel) begin
            alu_ctrl = seq_alu_ctrl;
            alu_op_a = seq_op_a;
            alu_op_b = seq_op_b;
        end else begin
            alu_ctrl = pipe_alu_ctrl;
            alu_op_a = pipe_op_a;
            alu_op_b = pipe_op_b;
        end
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier that borrows the core's shared ALU for its
// accumulate step and stalls the execute stage while it does so.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic             pipe_stall,
    input  logic [3:0]       pipe_alu_ctrl,
    input  logic [XLEN-1:0]  pipe_op_a,
    input  logic [XLEN-1:0]  pipe_op_b,
    output logic [3:0]       alu_ctrl,
    output logic [XLEN-1:0]  alu_op_a,
    output logic [XLEN-1:0]  alu_op_b,
    input  logic [XLEN-1:0]  alu_res,
    output logic [CNT_W-1:0] iter_cnt
);

    mul_state_t state_q, state_d;

    logic [XLEN-1:0] mcand, mplier, acc;
    logic            seq_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)     state_d = ST_CALC;
            ST_CALC: if (mplier == '0)  state_d = ST_DONE;
            ST_DONE: if (resp_ready)    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        pipe_stall = 1'b1;
        seq_sel    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                req_ready  = 1'b1;
                pipe_stall = 1'b0;
                seq_sel    = 1'b0;
            end
            ST_DONE: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // One multiplier bit per cycle; the loop ends as soon as no set bits remain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            resp_data <= '0;
            iter_cnt  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        mcand    <= req_a;
                        mplier   <= req_b;
                        acc      <= '0;
                        iter_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    if (mplier == '0) begin
                        resp_data <= acc;
                    end else begin
                        if (mplier[0]) acc <= alu_res;
                        mcand    <= mcand << 1;
                        mplier   <= mplier >> 1;
                        iter_cnt <= iter_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    alu_src_mux #(
        .XLEN (XLEN)
    ) u_alu_src_mux (
        .seq_sel       (seq_sel),
        .pipe_alu_ctrl (pipe_alu_ctrl),
        .pipe_op_a     (pipe_op_a),
        .pipe_op_b     (pipe_op_b),
        .seq_alu_ctrl  (ALU_ADD),
        .seq_op_a      (acc),
        .seq_op_b      (mcand),
        .alu_ctrl      (alu_ctrl),
        .alu_op_a      (alu_op_a),
        .alu_op_b      (alu_op_b)
    );

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and randomized bench for alu_mul_seq with a behavioural ALU and
// a plain-arithmetic reference for product, latency and step count.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        pipe_stall;
    logic [3:0]  pipe_alu_ctrl;
    logic [31:0] pipe_op_a, pipe_op_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_op_a, alu_op_b;
    logic [31:0] alu_res;
    logic [5:0]  iter_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Shared ALU, combinational.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD: alu_res = alu_op_a + alu_op_b;
            ALU_SUB: alu_res = alu_op_a - alu_op_b;
            ALU_AND: alu_res = alu_op_a & alu_op_b;
            ALU_OR:  alu_res = alu_op_a | alu_op_b;
            ALU_XOR: alu_res = alu_op_a ^ alu_op_b;
            default: alu_res = '0;
        endcase
    end

    alu_mul_seq #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .pipe_stall    (pipe_stall),
        .pipe_alu_ctrl (pipe_alu_ctrl),
        .pipe_op_a     (pipe_op_a),
        .pipe_op_b     (pipe_op_b),
        .alu_ctrl      (alu_ctrl),
        .alu_op_a      (alu_op_a),
        .alu_op_b      (alu_op_b),
        .alu_res       (alu_res),
        .iter_cnt      (iter_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Position of the highest set bit of b, or -1 when b is zero.
    function automatic int top_bit(input logic [31:0] b);
        int k = -1;
        for (int i = 0; i < 32; i++)
            if (b[i]) k = i;
        return k;
    endfunction

    // Full transaction: accept, count edges to resp_valid, compare, release.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int hold_cycles);
        logic [63:0] wide;
        logic [31:0] exp_p;
        int          k, exp_lat, lat;
        logic [31:0] held;
        wide    = {32'd0, a} * {32'd0, b};
        exp_p   = wide[31:0];
        k       = top_bit(b);
        exp_lat = (k < 0) ? 1 : k + 2;

        check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            if (resp_valid) break;
            check({tag, ".busy_stall"}, {31'd0, pipe_stall}, 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".product"}, resp_data, exp_p);
        check({tag, ".iter_cnt"}, {26'd0, iter_cnt}, (k < 0) ? 32'd0 : 32'(k + 1));

        held = resp_data;
        for (int c = 0; c < hold_cycles; c++) begin
            @(posedge clk); #1;
            check({tag, ".hold_data"}, resp_data, held);
            check({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, ".hold_stall"}, {31'd0, pipe_stall}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
            check({tag, ".hold_aluctrl"}, {28'd0, alu_ctrl}, {28'd0, ALU_ADD});
        end

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, ".idle_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, ".kept_data"}, resp_data, exp_p);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rstn          = 1'b0;
        req_valid     = 1'b0;
        req_a         = '0;
        req_b         = '0;
        resp_ready    = 1'b0;
        pipe_alu_ctrl = ALU_XOR;
        pipe_op_a     = '0;
        pipe_op_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.stall", {31'd0, pipe_stall}, 32'd0);
        check("rst.resp_data", resp_data, 32'd0);
        check("rst.iter_cnt", {26'd0, iter_cnt}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        pipe_alu_ctrl = ALU_SUB;
        pipe_op_a     = 32'd10;
        pipe_op_b     = 32'd3;
        #1;
        check("pass.ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_SUB});
        check("pass.op_a", alu_op_a, 32'd10);
        check("pass.op_b", alu_op_b, 32'd3);
        check("pass.stall", {31'd0, pipe_stall}, 32'd0);

        run_mul("m3x5", 32'd3, 32'd5, 0);
        run_mul("zero_b", 32'h1234, 32'd0, 0);
        run_mul("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_mul("wrap", 32'h0001_0000, 32'h0001_0000, 0);
        run_mul("hold5", 32'd1234567, 32'd89, 5);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_mul("rand", ra, rb, $urandom_range(0, 2));
        end

        // Reset in the middle of a multiply must drop it without a response.
        req_a     = 32'h0000_0007;
        req_b     = 32'hFFFF_0000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort.busy", {31'd0, pipe_stall}, 32'd1);
        rstn = 1'b0;
        #1;
        check("abort.req_ready", {31'd0, req_ready}, 32'd1);
        check("abort.stall", {31'd0, pipe_stall}, 32'd0);
        check("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort.resp_data", resp_data, 32'd0);
        check("abort.iter_cnt", {26'd0, iter_cnt}, 32'd0);
        check("abort.pass_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_SUB});
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            check("abort.no_resp", {31'd0, resp_valid}, 32'd0);
        end

        run_mul("post_rst", 32'd6, 32'd7, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
